// File: rtl/mem_test_sequencer_if.sv
// rtl/mem_test_sequencer_if.sv - single-port synchronous memory bus between sequencer and RAM
interface mem_test_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;

  // Sequencer side: drives address, strobe and write data, receives read data.
  modport master (
    output addr,
    output we,
    output data_out,
    input  data_in
  );

  // Memory side.
  modport slave (
    input  addr,
    input  we,
    input  data_out,
    output data_in
  );
endinterface

// File: rtl/mem_test_sequencer.sv
// rtl/mem_test_sequencer.sv - write-then-verify memory test sequencer; optional step_btn debounce under DEBOUNCE_EN
module mem_test_sequencer #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int NUM_WORDS       = 3,
  parameter int ADDR_STRIDE     = 16,
  parameter int BASE_ADDR       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_btn_i,
  input  logic                    auto_mode_i,
  input  logic                    start_i,
  mem_test_sequencer_if.master    mem,
  output logic [2:0]              state_o,
  output logic                    busy_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic [ADDR_W-1:0]       fail_addr_o
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_SETUP  = 3'd1,
    S_W_STROBE = 3'd2,
    S_R_SETUP  = 3'd3,
    S_R_WAIT   = 3'd4,
    S_CHECK    = 3'd5,
    S_PASS     = 3'd6,
    S_FAIL     = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_next;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;

  logic sync1_q, sync2_q;
  logic btn_level;
  logic level_prev_q;
  logic step_pulse;
  logic adv;

  // Address of pattern word i, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pattern_addr(input logic [IDX_W-1:0] i);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(i) * ADDR_W'(ADDR_STRIDE);
  endfunction

  // Data of pattern word i is i+1, wrapping modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] pattern_data(input logic [IDX_W-1:0] i);
    return DATA_W'(i) + DATA_W'(1);
  endfunction

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= step_btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [DB_W-1:0] db_cnt_q;
  logic            db_level_q;

  // Accept a new button level only after it has held for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
    end else if (sync2_q == db_level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_level_q <= sync2_q;
      db_cnt_q   <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign btn_level = db_level_q;
`else
  assign btn_level = sync2_q;
`endif

  // Previous button level for rising-edge detection; a held button gives one pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= btn_level;
    end
  end

  assign step_pulse = btn_level & ~level_prev_q;
  assign adv        = auto_mode_i | step_pulse;
  assign idx_next   = idx_q + IDX_W'(1);

  // State and registered memory-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  // Next-state logic; addr/data are loaded on entry to each setup state so
  // the memory sees them at least one cycle before the strobe rises.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    fail_addr_d = fail_addr_q;

    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start_i) begin
          state_d     = S_W_SETUP;
          idx_d       = '0;
          fail_addr_d = '0;
          addr_d      = pattern_addr('0);
          data_d      = pattern_data('0);
        end
      end

      S_W_SETUP: begin
        if (adv) begin
          state_d = S_W_STROBE;
          we_d    = 1'b1;
        end
      end

      // First cycle here has we high; the second cycle drops it and moves on.
      S_W_STROBE: begin
        if (!we_q) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            addr_d  = pattern_addr('0);
            state_d = S_R_SETUP;
          end else begin
            idx_d   = idx_next;
            addr_d  = pattern_addr(idx_next);
            data_d  = pattern_data(idx_next);
            state_d = S_W_SETUP;
          end
        end
      end

      S_R_SETUP: begin
        if (adv) begin
          state_d = S_R_WAIT;
        end
      end

      S_R_WAIT: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (mem.data_in != pattern_data(idx_q)) begin
          fail_addr_d = addr_q;
          state_d     = S_FAIL;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_PASS;
        end else begin
          idx_d   = idx_next;
          addr_d  = pattern_addr(idx_next);
          state_d = S_R_SETUP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem.addr     = addr_q;
  assign mem.we       = we_q;
  assign mem.data_out = data_q;

  assign state_o     = state_q;
  assign busy_o      = !(state_q inside {S_IDLE, S_PASS, S_FAIL});
  assign pass_o      = (state_q == S_PASS);
  assign fail_o      = (state_q == S_FAIL);
  assign fail_addr_o = fail_addr_q;

endmodule

// File: doc/mem_test_sequencer.md
Name: mem_test_sequencer

Overview:
Clocked controller that sequences a single-port synchronous data memory through a write-then-verify test. It writes NUM_WORDS pattern words at strided addresses, reads them back and compares them, and reports pass or fail. Each step advances on a debounced pushbutton (board bring-up) or free-runs in auto mode. It sits between the board I/O (buttons, LEDs) and the memory's addr/we/data ports.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
NUM_WORDS, 3, number of words written and verified (>=1)
ADDR_STRIDE, 16, address increment between words
BASE_ADDR, 0, address of word 0
DEBOUNCE_CYCLES, 50000, stable cycles required on step_btn (used only with DEBOUNCE_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
step_btn  in  1  raw pushbutton, active-high, asynchronous to clk
auto_mode  in  1  1 = advance every cycle, 0 = advance on step_btn press
start  in  1  level; begins a run from IDLE/PASS/FAIL
data_in  in  DATA_W  memory read data, valid 1 cycle after addr with we=0
addr  out  ADDR_W  memory address (registered)
we  out  1  memory write enable (registered)
data_out  out  DATA_W  memory write data (registered)
state  out  3  current state encoding, for LEDs
busy  out  1  high in any state other than IDLE/PASS/FAIL
pass  out  1  high while in PASS
fail  out  1  high while in FAIL
fail_addr  out  ADDR_W  address of first mismatch; held until next start

Behaviour:
- Reset: state=IDLE, addr=0, we=0, data_out=0, fail_addr=0, idx=0, pass/fail/busy=0. Asynchronous, so we drops immediately even mid-write.
- step_btn: 2-flop synchronizer, then rising-edge detect gives a one-cycle step_pulse. Holding the button yields one pulse. adv = auto_mode | step_pulse.
- Pattern word for index i: addr = BASE_ADDR + i*ADDR_STRIDE mod 2^ADDR_W; data = (i+1) mod 2^DATA_W.
- States (encoding):
  - IDLE(0): we=0.
  - W_SETUP(1): addr/data_out driven, we=0.
  - W_STROBE(2): we=1.
  - R_SETUP(3): addr driven, we=0.
  - R_WAIT(4).
  - CHECK(5).
  - PASS(6).
  - FAIL(7).
- IDLE/PASS/FAIL: on start=1, clear pass/fail/fail_addr, set idx=0, go to W_SETUP. adv is not required.
- W_SETUP: on adv, go to W_STROBE.
- W_STROBE: we=1 for exactly one clk, independent of adv. Next cycle: we=0. If idx==NUM_WORDS-1, set idx=0 and go to R_SETUP; else idx+1 and go to W_SETUP.
- R_SETUP: on adv, go to R_WAIT.
- R_WAIT: one unconditional cycle (memory read latency), then CHECK.
- CHECK: one unconditional cycle; compares data_in with pattern(idx).
  - Mismatch: capture fail_addr=addr, go to FAIL.
  - Match and idx==NUM_WORDS-1: go to PASS.
  - Otherwise: idx+1, go to R_SETUP.
- addr and data_out hold stable from W_SETUP through W_STROBE. Memory sees addr/data one cycle before we rises.
- start while busy: ignored.
- auto_mode toggled mid-run: takes effect on the next cycle.
- step_pulse outside W_SETUP/R_SETUP: discarded, not queued.
- NUM_WORDS=1: a single write, single read; CHECK goes directly to PASS/FAIL.
- Address overflow: wraps modulo 2^ADDR_W, no error flagged.
- Auto-mode run length: 3*NUM_WORDS + 3*NUM_WORDS + 1 cycles from start to PASS.

Optional Feature:
DEBOUNCE_EN:
- Defined: the synchronized step_btn must hold a new level for DEBOUNCE_CYCLES consecutive clks before the debounced level changes. Edge detect runs on the debounced level, and glitches shorter than DEBOUNCE_CYCLES produce no step_pulse.
- Undefined: edge detect runs directly on the synchronizer output; the DEBOUNCE_CYCLES counter is not instantiated.

Test Plan:
- Reset, auto_mode=1, start pulse, ideal RAM model -> writes (0,1),(16,2),(32,3) each with exactly one we cycle; pass=1, state=6 after 19 cycles.
- RAM model corrupts address 16 on read -> FAIL (state=7), fail_addr=16, pass=0, no read issued to address 32.
- auto_mode=0, step_btn held high 100 cycles -> exactly one advance (W_SETUP->W_STROBE); we high one cycle only.
- Assert reset while in W_STROBE (we=1) -> we=0 in the same cycle, state=0, all outputs zero.
- start asserted during R_SETUP -> ignored; run completes to PASS normally; start after PASS clears pass and restarts at addr 0.
- With DEBOUNCE_EN, DEBOUNCE_CYCLES=8: 5-cycle step_btn glitch -> no advance; 10-cycle press -> one advance.
